seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Reads back a multiplexed 4-digit 7-segment display bus (segment lines plus one-hot digit select) and reconstructs the displayed BCD digits, decimal points and blank state. It sits on the display side of the BCD counter / segment blink path and lets self-checks, or a host, read what the display actually shows. It filters mux transitions with a settle window, assembles complete frames, and flags illegal glyphs and select faults.

## Interface
- SETTLE, 4: consecutive clocks a digit's select and segment pattern must be stable before capture; legal range 1..15.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seg  in  8  segment lines, active-high; bit0=a … bit6=g, bit7=dp; synchronous to clk.
- an  in  4  digit select, active-high; an[0] = rightmost digit.
- digits  out  16  BCD frame; digits[4i+3:4i] = digit i.
- dp  out  4  decimal point per digit in the last frame.
- blank  out  4  digit showed all-off segments (bits 6:0 = 0) in the last frame.
- frame_valid  out  1  one-clock pulse when digits/dp/blank update.
- code_err  out  1  one-clock pulse: settled pattern is not a legal glyph.
- an_err  out  1  one-clock pulse: an has more than one bit set.

## Operation
- Legal glyphs on seg[6:0]: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, blank=0x00. dp is independent of the glyph.
- Stability tracker: registers previous {an, seg}. Stable counter increments while {an, seg} equals the previous value and an is one-hot. It clears to 0 on any change, on an==0, or on multi-hot an. The counter saturates; it does not wrap.
- Capture fires once per stable window, when the counter reaches SETTLE-1, meaning the pattern was present on SETTLE consecutive edges. A captured flag blocks a second capture until {an, seg} changes.
- Capture of digit i writes into the shadow registers:
  - legal digit: shadow value = BCD, blank_i = 0;
  - blank glyph: value unchanged, blank_i = 1;
  - illegal glyph: value unchanged, blank_i = 0, code_err pulses, and seen[i] is not set.
- Capture of a legal or blank digit also sets dp_i = seg[7] and seen[i] = 1.
- Frame assembly: when seen == 4'hF, shadow is copied to digits/dp/blank, frame_valid pulses, and seen clears. A recapture of an already-seen digit before frame completion overwrites the shadow value (newest wins).
- Any multi-hot an pulses an_err on every clock it persists; no capture occurs.
- Blinking display: alternating blank and digit frames are reported faithfully. digits keeps the last non-blank value of each digit.

## Timing
- Reset values: digits=0, dp=0, blank=4'hF, frame_valid=0, code_err=0, an_err=0. Reset also clears seen, the shadow registers, the stable counter, the captured flag and the previous-input registers.
- Reset has priority over all events. Reset mid-frame discards the partial frame, and no frame_valid follows.
- Capture latency: the pattern must appear at edge k and hold through edge k+SETTLE-1. The shadow is updated at edge k+SETTLE. With SETTLE=1, the shadow updates on the edge after the first sample.
- Outputs update, and frame_valid pulses, one clock after the capture that completes seen. Outputs are registered and hold between frames.
- code_err and an_err are registered; each asserts one clock after the offending condition is sampled.
- A capture completing a frame in the same cycle as a new capture cannot occur, because captures happen at most once per clock.

## Test plan
- Reset: assert rst 2 cycles, then scan nothing -> digits=0x0000, blank=4'hF, dp=0, no pulses.
- Scan "1234" (an 1000/0100/0010/0001, seg 0x06/0x5B/0x4F/0x66, 8 clocks each, SETTLE=4) -> one frame_valid; digits=0x1234, blank=0, dp=0.
- Glitch: select digit 0 with 0x7F for 3 clocks, then 0x6F for 8 -> only 9 captured; 0x7F never appears in digits[3:0].
- Illegal glyph 0x49 on digit 2 for 8 clocks -> single code_err pulse; the frame waits until digit 2 shows a legal or blank glyph.
- Blink: frames "0042" then all digits 0x00 -> blank=4'hF, digits stays 0x0042; a further "0042" frame -> blank=0.
- an=4'b0011 for 5 clocks -> an_err high 5 cycles, no capture; rst asserted after 3 of 4 digits captured -> no frame_valid, outputs at reset values.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// Display-bus readback interface: the scanned segment/select lines going in,
// the reconstructed frame and fault pulses coming out.
interface seg_scan_decoder_if;
  logic [7:0]  seg;          // bit0=a .. bit6=g, bit7=dp
  logic [3:0]  an;           // one-hot digit select, an[0] = rightmost
  logic [15:0] digits;       // digits[4i+3:4i] = BCD of digit i
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        code_err;
  logic        an_err;

  // Side that drives the display bus and consumes the decoded frame.
  modport master (
    output seg, an,
    input  digits, dp, blank, frame_valid, code_err, an_err
  );

  // The decoder itself.
  modport slave (
    input  seg, an,
    output digits, dp, blank, frame_valid, code_err, an_err
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Reconstructs what a multiplexed 4-digit 7-segment display shows.
// A pattern (select + segments) must hold for SETTLE consecutive edges before
// it is captured into a per-digit shadow; once every digit has been captured
// the shadow is published as one frame.
module seg_scan_decoder #(
  parameter int SETTLE = 4   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_decoder_if.slave bus
);

  // Counter value seen on the edge that completes a SETTLE-long stable run.
  localparam logic [3:0] LP_CAP_CNT = 4'(SETTLE - 1);

  // Stability tracker state
  logic [3:0]  r_prev_an;
  logic [7:0]  r_prev_seg;
  logic [3:0]  r_cnt;
  logic        r_captured;

  // Frame assembly / output state
  logic [3:0]  r_seen;
  logic [15:0] r_digits;
  logic [3:0]  r_dp;
  logic [3:0]  r_blank;
  logic        r_frame_valid;
  logic        r_code_err;
  logic        r_an_err;

  logic        w_same;
  logic        w_an_multi;
  logic        w_an_onehot;
  logic        w_prev_onehot;
  logic        w_capture;
  logic        w_glyph_digit;
  logic        w_glyph_blank;
  logic [3:0]  w_glyph_bcd;
  logic [3:0]  w_seen_next;
  logic [15:0] w_sh_val;
  logic [3:0]  w_sh_dp;
  logic [3:0]  w_sh_blank;

  assign w_same        = ({bus.an, bus.seg} == {r_prev_an, r_prev_seg});
  assign w_an_multi    = (bus.an & (bus.an - 4'd1)) != 4'd0;
  assign w_an_onehot   = (bus.an != 4'd0) && !w_an_multi;
  assign w_prev_onehot = (r_prev_an != 4'd0) &&
                         ((r_prev_an & (r_prev_an - 4'd1)) == 4'd0);

  // The captured pattern is the registered copy: it was on the bus for the
  // SETTLE edges that ended with the previous one. The one-hot check matters
  // for SETTLE=1, where a zero count also follows an idle or multi-hot bus.
  assign w_capture = w_prev_onehot && (r_cnt == LP_CAP_CNT) && !r_captured;

  // Track how long the current one-hot pattern has been stable; saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_an  <= 4'd0;
      r_prev_seg <= 8'd0;
      r_cnt      <= 4'd0;
      r_captured <= 1'b0;
    end else begin
      r_prev_an  <= bus.an;
      r_prev_seg <= bus.seg;
      if (w_same && w_an_onehot) begin
        r_cnt <= (r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end
      // A new pattern re-arms capture even if the old one fires this edge.
      if (!w_same) begin
        r_captured <= 1'b0;
      end else if (w_capture) begin
        r_captured <= 1'b1;
      end
    end
  end

  // Decode the captured segment pattern into BCD / blank / illegal.
  always_comb begin
    w_glyph_digit = 1'b1;
    w_glyph_blank = 1'b0;
    w_glyph_bcd   = 4'd0;
    case (r_prev_seg[6:0])
      7'h3F: w_glyph_bcd = 4'd0;
      7'h06: w_glyph_bcd = 4'd1;
      7'h5B: w_glyph_bcd = 4'd2;
      7'h4F: w_glyph_bcd = 4'd3;
      7'h66: w_glyph_bcd = 4'd4;
      7'h6D: w_glyph_bcd = 4'd5;
      7'h7D: w_glyph_bcd = 4'd6;
      7'h07: w_glyph_bcd = 4'd7;
      7'h7F: w_glyph_bcd = 4'd8;
      7'h6F: w_glyph_bcd = 4'd9;
      7'h00: begin
        w_glyph_digit = 1'b0;
        w_glyph_blank = 1'b1;
      end
      default: w_glyph_digit = 1'b0;
    endcase
  end

  // Per-digit shadow registers; blank and illegal glyphs keep the old value
  // so the published digits always hold the last real number shown.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0] r_val;
    logic       r_sh_dp;
    logic       r_sh_blank;
    logic       w_hit;

    assign w_hit = w_capture && r_prev_an[gi];

    // Update this digit's shadow on its own capture.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_val      <= 4'd0;
        r_sh_dp    <= 1'b0;
        r_sh_blank <= 1'b0;
      end else if (w_hit) begin
        if (w_glyph_digit) begin
          r_val      <= w_glyph_bcd;
          r_sh_blank <= 1'b0;
          r_sh_dp    <= r_prev_seg[7];
        end else if (w_glyph_blank) begin
          r_sh_blank <= 1'b1;
          r_sh_dp    <= r_prev_seg[7];
        end else begin
          r_sh_blank <= 1'b0;
        end
      end
    end

    assign w_sh_val[4*gi +: 4] = r_val;
    assign w_sh_dp[gi]         = r_sh_dp;
    assign w_sh_blank[gi]      = r_sh_blank;
  end

  // Seen mask: a full mask is published and cleared; a capture on the same
  // edge already belongs to the next frame.
  always_comb begin
    w_seen_next = r_seen;
    if (r_seen == 4'hF) begin
      w_seen_next = 4'h0;
    end
    if (w_capture && (w_glyph_digit || w_glyph_blank)) begin
      w_seen_next = w_seen_next | r_prev_an;
    end
  end

  // Frame publication and registered fault pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen        <= 4'h0;
      r_digits      <= 16'h0000;
      r_dp          <= 4'h0;
      r_blank       <= 4'hF;
      r_frame_valid <= 1'b0;
      r_code_err    <= 1'b0;
      r_an_err      <= 1'b0;
    end else begin
      r_seen        <= w_seen_next;
      r_frame_valid <= (r_seen == 4'hF);
      if (r_seen == 4'hF) begin
        r_digits <= w_sh_val;
        r_dp     <= w_sh_dp;
        r_blank  <= w_sh_blank;
      end
      r_code_err <= w_capture && !w_glyph_digit && !w_glyph_blank;
      r_an_err   <= w_an_multi;
    end
  end

  assign bus.digits      = r_digits;
  assign bus.dp          = r_dp;
  assign bus.blank       = r_blank;
  assign bus.frame_valid = r_frame_valid;
  assign bus.code_err    = r_code_err;
  assign bus.an_err      = r_an_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed display scenarios plus
// randomized scanning, all compared every clock against a run-length model.
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_decoder_if u_if ();

  seg_scan_decoder #(.SETTLE(SETTLE)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Glyph table indexed by BCD value.
  logic [6:0] glyph_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model state
  int          run_len;
  logic [11:0] run_pat;
  logic        pend_cap;
  logic [11:0] pend_pat;
  logic [3:0]  sh_val   [4];
  logic        sh_dp    [4];
  logic        sh_blank [4];
  logic [3:0]  m_seen;
  logic [15:0] exp_digits;
  logic [3:0]  exp_dp;
  logic [3:0]  exp_blank;
  logic        exp_fv;
  logic        exp_ce;
  logic        exp_ae;

  // Observed pulse counts for scenario-level checks
  int cnt_fv;
  int cnt_ce;
  int cnt_ae;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 0..9 = digit, 10 = blank, -1 = illegal
  function automatic int decode(input logic [6:0] g);
    if (g == 7'h00) return 10;
    for (int k = 0; k < 10; k++) begin
      if (glyph_tbl[k] == g) return k;
    end
    return -1;
  endfunction

  function automatic bit is_onehot(input logic [3:0] a);
    return $countones(a) == 1;
  endfunction

  // Model of one rising edge, given the inputs sampled on it.
  task automatic model_edge();
    logic [11:0] s;
    int          idx;
    int          g;
    s = {u_if.an, u_if.seg};
    if (rst) begin
      run_len  = 0;
      run_pat  = '0;
      pend_cap = 1'b0;
      pend_pat = '0;
      for (int i = 0; i < 4; i++) begin
        sh_val[i] = 4'd0; sh_dp[i] = 1'b0; sh_blank[i] = 1'b0;
      end
      m_seen = 4'h0;
      exp_digits = 16'h0; exp_dp = 4'h0; exp_blank = 4'hF;
      exp_fv = 1'b0; exp_ce = 1'b0; exp_ae = 1'b0;
      return;
    end
    exp_fv = 1'b0;
    exp_ce = 1'b0;
    exp_ae = ($countones(u_if.an) > 1);
    // Publish a frame completed on the previous edge.
    if (m_seen == 4'hF) begin
      for (int i = 0; i < 4; i++) begin
        exp_digits[4*i +: 4] = sh_val[i];
        exp_dp[i]    = sh_dp[i];
        exp_blank[i] = sh_blank[i];
      end
      exp_fv = 1'b1;
      m_seen = 4'h0;
    end
    // Capture a pattern whose stable run completed on the previous edge.
    if (pend_cap) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (pend_pat[8 + i]) idx = i;
      g = decode(pend_pat[6:0]);
      if (g < 0) begin
        exp_ce = 1'b1;
        sh_blank[idx] = 1'b0;
      end else begin
        if (g == 10) sh_blank[idx] = 1'b1;
        else begin
          sh_val[idx]   = 4'(g);
          sh_blank[idx] = 1'b0;
        end
        sh_dp[idx] = pend_pat[7];
        m_seen[idx] = 1'b1;
      end
      pend_cap = 1'b0;
    end
    // Run length of the current one-hot pattern.
    if (is_onehot(u_if.an)) begin
      if (run_len > 0 && s == run_pat) run_len++;
      else begin
        run_pat = s;
        run_len = 1;
      end
    end else begin
      run_len = 0;
    end
    if (run_len == SETTLE) begin
      pend_cap = 1'b1;
      pend_pat = s;
    end
  endtask

  // One clock: model the edge, then compare all outputs just after it.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("digits",      32'(u_if.digits),      32'(exp_digits));
    check_eq("dp",          32'(u_if.dp),          32'(exp_dp));
    check_eq("blank",       32'(u_if.blank),       32'(exp_blank));
    check_eq("frame_valid", 32'(u_if.frame_valid), 32'(exp_fv));
    check_eq("code_err",    32'(u_if.code_err),    32'(exp_ce));
    check_eq("an_err",      32'(u_if.an_err),      32'(exp_ae));
    if (u_if.frame_valid === 1'b1) begin
      cnt_fv++;
      $display("[TB] frame digits=%h dp=%b blank=%b", u_if.digits, u_if.dp,
               u_if.blank);
    end
    if (u_if.code_err === 1'b1) cnt_ce++;
    if (u_if.an_err === 1'b1)   cnt_ae++;
  endtask

  task automatic drive(input logic [3:0] an, input logic [7:0] seg,
                       input int n);
    u_if.an  = an;
    u_if.seg = seg;
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic idle(input int n);
    drive(4'b0000, 8'h00, n);
  endtask

  // Scan four digits (d3 first), 8 clocks each; value 15 means blank.
  task automatic scan4(input logic [3:0] d3, input logic [3:0] d2,
                       input logic [3:0] d1, input logic [3:0] d0);
    logic [3:0] v [4];
    logic [6:0] g;
    v[3] = d3; v[2] = d2; v[1] = d1; v[0] = d0;
    for (int i = 3; i >= 0; i--) begin
      g = (v[i] == 4'hF) ? 7'h00 : glyph_tbl[v[i]];
      drive(4'(1 << i), {1'b0, g}, 8);
    end
  endtask

  task automatic clear_counts();
    cnt_fv = 0; cnt_ce = 0; cnt_ae = 0;
  endtask

  initial begin
    logic [3:0] an_r;
    logic [7:0] seg_r;
    int         r;
    u_if.an  = 4'b0;
    u_if.seg = 8'h00;
    clear_counts();

    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    idle(4);
    check_eq("rst_digits", 32'(u_if.digits), 32'h0000);
    check_eq("rst_blank",  32'(u_if.blank),  32'hF);
    check_eq("rst_dp",     32'(u_if.dp),     32'h0);
    check_eq("rst_pulses", 32'(cnt_fv + cnt_ce + cnt_ae), 32'd0);
    $display("[TB] reset done");

    // Scan "1234"
    clear_counts();
    scan4(4'd1, 4'd2, 4'd3, 4'd4);
    idle(3);
    check_eq("s1234_fv",     32'(cnt_fv),      32'd1);
    check_eq("s1234_digits", 32'(u_if.digits), 32'h1234);
    check_eq("s1234_blank",  32'(u_if.blank),  32'h0);
    check_eq("s1234_dp",     32'(u_if.dp),     32'h0);
    $display("[TB] scan 1234 done");

    // Glitch on digit 0: 0x7F too short, then 0x6F settles
    clear_counts();
    drive(4'b0001, 8'h7F, 3);
    drive(4'b0001, 8'h6F, 8);
    drive(4'b0010, {1'b0, glyph_tbl[7]}, 8);
    drive(4'b0100, {1'b0, glyph_tbl[6]}, 8);
    drive(4'b1000, {1'b0, glyph_tbl[5]}, 8);
    idle(3);
    check_eq("glitch_fv",  32'(cnt_fv),           32'd1);
    check_eq("glitch_d0",  32'(u_if.digits[3:0]), 32'd9);
    check_eq("glitch_all", 32'(u_if.digits),      32'h5679);
    $display("[TB] glitch done");

    // Illegal glyph on digit 2 holds the frame back
    clear_counts();
    drive(4'b1000, {1'b0, glyph_tbl[8]}, 8);
    drive(4'b0010, {1'b0, glyph_tbl[1]}, 8);
    drive(4'b0001, {1'b0, glyph_tbl[0]}, 8);
    drive(4'b0100, 8'h49, 8);
    idle(3);
    check_eq("illegal_ce", 32'(cnt_ce), 32'd1);
    check_eq("illegal_fv", 32'(cnt_fv), 32'd0);
    drive(4'b0100, {1'b0, glyph_tbl[5]}, 8);
    idle(3);
    check_eq("illegal_fv2",    32'(cnt_fv),      32'd1);
    check_eq("illegal_digits", 32'(u_if.digits), 32'h8510);
    $display("[TB] illegal glyph done");

    // Blink: "0042", all blank, "0042"
    clear_counts();
    scan4(4'd0, 4'd0, 4'd4, 4'd2);
    idle(2);
    scan4(4'hF, 4'hF, 4'hF, 4'hF);
    idle(2);
    check_eq("blink_blank",  32'(u_if.blank),  32'hF);
    check_eq("blink_digits", 32'(u_if.digits), 32'h0042);
    scan4(4'd0, 4'd0, 4'd4, 4'd2);
    idle(2);
    check_eq("blink_unblank", 32'(u_if.blank), 32'h0);
    check_eq("blink_fv",      32'(cnt_fv),     32'd3);
    $display("[TB] blink done");

    // Multi-hot select
    clear_counts();
    drive(4'b0011, {1'b0, glyph_tbl[3]}, 5);
    idle(3);
    check_eq("multi_ae", 32'(cnt_ae), 32'd5);
    check_eq("multi_fv", 32'(cnt_fv), 32'd0);
    check_eq("multi_ce", 32'(cnt_ce), 32'd0);
    $display("[TB] multi-hot select done");

    // Reset mid-frame
    clear_counts();
    drive(4'b1000, {1'b0, glyph_tbl[9]}, 8);
    drive(4'b0100, {1'b0, glyph_tbl[8]}, 8);
    drive(4'b0010, {1'b0, glyph_tbl[7]}, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);
    drive(4'b0001, {1'b0, glyph_tbl[6]}, 8);
    idle(3);
    check_eq("midrst_fv",     32'(cnt_fv),      32'd0);
    check_eq("midrst_digits", 32'(u_if.digits), 32'h0000);
    check_eq("midrst_blank",  32'(u_if.blank),  32'hF);
    check_eq("midrst_dp",     32'(u_if.dp),     32'h0);
    $display("[TB] mid-frame reset done");

    // Randomized scanning
    clear_counts();
    for (int t = 0; t < 500; t++) begin
      r = int'($urandom_range(0, 15));
      if (r < 13)       an_r = 4'(1 << $urandom_range(0, 3));
      else if (r == 13) an_r = 4'b0000;
      else begin
        an_r = 4'($urandom_range(0, 15));
        while ($countones(an_r) < 2) an_r = 4'($urandom_range(0, 15));
      end
      r = int'($urandom_range(0, 9));
      if (r < 7)       seg_r = {1'b0, glyph_tbl[$urandom_range(0, 9)]};
      else if (r == 7) seg_r = 8'h00;
      else             seg_r = 8'($urandom_range(0, 255));
      seg_r[7] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 80) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      drive(an_r, seg_r, int'($urandom_range(1, 10)));
    end
    idle(3);
    $display("[TB] random phase done, frames=%0d", cnt_fv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
